// File: rtl/gpio_int_rst_gen.sv
// Global reset sequencer: holds the active-low global reset through POR/HOLD,
// waits for all PLLs to be stably locked, then releases; records sticky reset causes.
module gpio_int_rst_gen #(
  parameter int N_PLL           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYC        = 16,
  parameter int LOCK_STABLE_CYC = 1024
) (
  input  logic             clk_50m,
  input  logic             rst_50m,
  input  logic [N_PLL-1:0] i_pll_locked,
  input  logic             i_sw_rst_req,
  input  logic             i_wdt_expire,
  input  logic             i_cause_clr,
  output logic             o_rstn_50m,
  output logic [3:0]       o_rst_cause,
  output logic             o_rst_active,
  output logic [1:0]       o_state
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int LW = $clog2(LOCK_STABLE_CYC) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [HW-1:0]                   hold_cnt_q, hold_cnt_d;
  logic [LW-1:0]                   lock_cnt_q, lock_cnt_d;
  logic [SYNC_STAGES-1:0][N_PLL-1:0] sync_q, sync_d;
  logic [3:0]                      cause_q, cause_d;
  logic [3:0]                      cause_set;
  logic                            rstn_q, rstn_d;
  logic                            active_q, active_d;
  logic                            all_locked;

  // Stage 0 samples the raw lock flags; the last stage is the only one used.
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], i_pll_locked};
  assign all_locked = &sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lock_cnt_d = lock_cnt_q;
    cause_set  = 4'b0000;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_WAIT_LOCK;
          hold_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (!all_locked) begin
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          if (lock_cnt_q == LOCK_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cause_set = {i_wdt_expire, i_sw_rst_req, !all_locked, 1'b0};
        if (|cause_set) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    // A clear in the same cycle as an event keeps only the new event.
    cause_d  = (i_cause_clr ? 4'b0000 : cause_q) | cause_set;
    rstn_d   = (state_d == ST_RUN);
    active_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      lock_cnt_q <= '0;
      sync_q     <= '0;
      cause_q    <= 4'b0001;
      rstn_q     <= 1'b0;
      active_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      sync_q     <= sync_d;
      cause_q    <= cause_d;
      rstn_q     <= rstn_d;
      active_q   <= active_d;
    end
  end

  assign o_rstn_50m   = rstn_q;
  assign o_rst_active = active_q;
  assign o_rst_cause  = cause_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_gpio_int_rst_gen.sv
// Directed bench for gpio_int_rst_gen with HOLD_CYC=4, LOCK_STABLE_CYC=8.
module tb_gpio_int_rst_gen;

  logic       clk_50m = 1'b0;
  logic       rst_50m = 1'b1;
  logic [1:0] i_pll_locked = 2'b11;
  logic       i_sw_rst_req = 1'b0;
  logic       i_wdt_expire = 1'b0;
  logic       i_cause_clr = 1'b0;
  logic       o_rstn_50m;
  logic [3:0] o_rst_cause;
  logic       o_rst_active;
  logic [1:0] o_state;

  int vectors = 0;
  int miscompares = 0;

  gpio_int_rst_gen #(
    .N_PLL(2), .SYNC_STAGES(2), .HOLD_CYC(4), .LOCK_STABLE_CYC(8)
  ) dut (
    .clk_50m(clk_50m), .rst_50m(rst_50m), .i_pll_locked(i_pll_locked),
    .i_sw_rst_req(i_sw_rst_req), .i_wdt_expire(i_wdt_expire),
    .i_cause_clr(i_cause_clr), .o_rstn_50m(o_rstn_50m),
    .o_rst_cause(o_rst_cause), .o_rst_active(o_rst_active), .o_state(o_state)
  );

  always #5 clk_50m = ~clk_50m;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rstn, input logic [1:0] st,
                           input logic [3:0] cause);
    check({tag, "_rstn"}, 32'(o_rstn_50m), 32'(rstn));
    check({tag, "_state"}, 32'(o_state), 32'(st));
    check({tag, "_cause"}, 32'(o_rst_cause), 32'(cause));
    check({tag, "_active"}, 32'(o_rst_active), 32'(!rstn));
  endtask

  initial begin
    // Reset values while rst_50m is held
    #12;
    check_all("por_hold", 1'b0, 2'd0, 4'b0001);
    step(1);
    rst_50m = 1'b0;

    // 1. POR release: WAIT_LOCK at edge 4, RUN at edge 12
    step(3);
    check("s1_e3_state", 32'(o_state), 32'd0);
    step(1);
    check_all("s1_e4", 1'b0, 2'd1, 4'b0001);
    step(7);
    check_all("s1_e11", 1'b0, 2'd1, 4'b0001);
    step(1);
    check_all("s1_e12", 1'b1, 2'd2, 4'b0001);

    // 3. PLL loss in RUN: two synchroniser edges then the state edge
    i_pll_locked = 2'b10;
    step(1);
    check("s3_t1_rstn", 32'(o_rstn_50m), 32'd1);
    step(2);
    check_all("s3_t3", 1'b0, 2'd0, 4'b0011);
    i_pll_locked = 2'b11;
    step(11);
    check_all("s3_t14", 1'b0, 2'd1, 4'b0011);
    step(1);
    check_all("s3_t15", 1'b1, 2'd2, 4'b0011);

    // 4. SW + WDT + clear in the same cycle
    i_sw_rst_req = 1'b1;
    i_wdt_expire = 1'b1;
    i_cause_clr  = 1'b1;
    step(1);
    i_sw_rst_req = 1'b0;
    i_wdt_expire = 1'b0;
    i_cause_clr  = 1'b0;
    check_all("s4_e", 1'b0, 2'd0, 4'b1100);

    // 5. Requests during HOLD and WAIT_LOCK are ignored
    step(1);
    i_sw_rst_req = 1'b1;
    step(1);
    i_sw_rst_req = 1'b0;
    check_all("s5_hold", 1'b0, 2'd0, 4'b1100);
    step(3);
    check("s5_e5_state", 32'(o_state), 32'd1);
    i_sw_rst_req = 1'b1;
    i_wdt_expire = 1'b1;
    step(1);
    i_sw_rst_req = 1'b0;
    i_wdt_expire = 1'b0;
    check_all("s5_wait", 1'b0, 2'd1, 4'b1100);
    step(5);
    check("s5_e11_rstn", 32'(o_rstn_50m), 32'd0);
    step(1);
    check_all("s5_e12", 1'b1, 2'd2, 4'b1100);

    // Clear alone in RUN leaves the reset released
    i_cause_clr = 1'b1;
    step(1);
    i_cause_clr = 1'b0;
    check_all("clr_run", 1'b1, 2'd2, 4'b0000);

    // Watchdog alone
    i_wdt_expire = 1'b1;
    step(1);
    i_wdt_expire = 1'b0;
    check_all("wdt", 1'b0, 2'd0, 4'b1000);

    // 6. Asynchronous reset mid-WAIT_LOCK, between edges
    step(5);
    check("s6_pre_state", 32'(o_state), 32'd1);
    #3;
    rst_50m = 1'b1;
    #1;
    check_all("s6_async", 1'b0, 2'd0, 4'b0001);
    #1;
    rst_50m = 1'b0;
    step(4);
    check("s6_e4_state", 32'(o_state), 32'd1);
    step(7);
    check_all("s6_e11", 1'b0, 2'd1, 4'b0001);
    step(1);
    check_all("s6_e12", 1'b1, 2'd2, 4'b0001);

    // 2. One-cycle lock glitch in WAIT_LOCK restarts the stability count
    rst_50m = 1'b1;
    step(1);
    rst_50m = 1'b0;
    step(7);
    i_pll_locked = 2'b01;
    step(1);
    i_pll_locked = 2'b11;
    step(4);
    check_all("s2_e12", 1'b0, 2'd1, 4'b0001);
    step(5);
    check_all("s2_e17", 1'b0, 2'd1, 4'b0001);
    step(1);
    check_all("s2_e18", 1'b1, 2'd2, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
